axi_log_drain: RTL and testbench

// Downstream consumer of the AXI BRAM logger. On a software start, or on the logger's

---
 rtl/axi_log_pkg.sv | 31 +++
 rtl/axi_log_drain_if.sv | 13 +
 rtl/axi_log_entry_buf.sv | 77 +++++++
 rtl/axi_log_drain.sv | 148 ++++++++++++++
 tb/tb_axi_log_drain.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_log_pkg.sv
// Shared definitions for the log drain: entry geometry, field offsets and FSM states.
package axi_log_pkg;

   localparam int LOG_WORDS_PER_ENTRY = 3;
   localparam int LOG_WORD_BITW       = 32;
   localparam int LOG_ENTRY_BITW      = 96;

   localparam int LOG_TS_LSB    = 0;
   localparam int LOG_TS_BITW   = 32;
   localparam int LOG_ADDR_LSB  = 32;
   localparam int LOG_ADDR_BITW = 32;
   localparam int LOG_LEN_LSB   = 64;
   localparam int LOG_LEN_BITW  = 8;
   localparam int LOG_ID_LSB    = 72;
   localparam int LOG_ID_BITW   = 24;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      CHECK,
      EMIT,
      CLEAR,
      CLRWAIT
   } drain_state_e;

   // The logger allocates its slots in blocks of 1024.
   function automatic int num_slots(input int num_entries);
      return ((num_entries + 1023) / 1024) * 1024;
   endfunction

endpackage

// File: rtl/axi_log_drain_if.sv
// Valid/ready beat stream carrying drained log words to the consumer.
interface axi_log_drain_if;
   import axi_log_pkg::*;

   logic                     OutValid_S;
   logic                     OutReady_S;
   logic [LOG_WORD_BITW-1:0] OutData_D;
   logic                     OutLast_S;

   modport master (output OutValid_S, output OutData_D, output OutLast_S, input OutReady_S);
   modport slave  (input OutValid_S, input OutData_D, input OutLast_S, output OutReady_S);

endinterface

// File: rtl/axi_log_entry_buf.sv
// Three-word entry capture buffer, all-zero detect and the three-beat stream sequencer.
module axi_log_entry_buf
   import axi_log_pkg::*;
(
   input  logic                     Clk_CI,
   input  logic                     Rst_RI,
   input  logic                     CapEn_SI,
   input  logic [1:0]               CapIdx_DI,
   input  logic [LOG_WORD_BITW-1:0] CapData_DI,
   input  logic                     EmitStart_SI,
   input  logic                     LastEntry_SI,
   output logic                     AllZero_SO,
   output logic                     EmitDone_SO,
   axi_log_drain_if.master          out_if
);

   logic [LOG_ENTRY_BITW-1:0] entry;

   for (genvar gi = 0; gi < LOG_WORDS_PER_ENTRY; gi++) begin : g_word
      logic [LOG_WORD_BITW-1:0] word_q;
      always_ff @(posedge Clk_CI) begin
         if (Rst_RI) begin
            word_q <= '0;
         end else if (CapEn_SI && CapIdx_DI == 2'(gi)) begin
            word_q <= CapData_DI;
         end
      end
      assign entry[gi*LOG_WORD_BITW +: LOG_WORD_BITW] = word_q;
   end

   logic [LOG_WORD_BITW-1:0] ts_word, addr_word, idlen_word;
   assign ts_word    = entry[LOG_TS_LSB +: LOG_TS_BITW];
   assign addr_word  = entry[LOG_ADDR_LSB +: LOG_ADDR_BITW];
   assign idlen_word = {entry[LOG_ID_LSB +: LOG_ID_BITW], entry[LOG_LEN_LSB +: LOG_LEN_BITW]};

   assign AllZero_SO = ~|entry;

   logic                     valid_q;
   logic [1:0]               beat_q;
   logic [LOG_WORD_BITW-1:0] data_q;
   logic                     last_q;
   logic                     fire;

   // Ready only advances registered state, so valid never depends on ready in the same cycle.
   assign fire        = valid_q & out_if.OutReady_S;
   assign EmitDone_SO = fire && (beat_q == 2'd2);

   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         valid_q <= 1'b0;
         beat_q  <= 2'd0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else if (EmitStart_SI) begin
         valid_q <= 1'b1;
         beat_q  <= 2'd0;
         data_q  <= ts_word;
         last_q  <= 1'b0;
      end else if (fire) begin
         if (beat_q == 2'd2) begin
            valid_q <= 1'b0;
            beat_q  <= 2'd0;
            data_q  <= '0;
            last_q  <= 1'b0;
         end else begin
            beat_q <= beat_q + 2'd1;
            data_q <= (beat_q == 2'd0) ? addr_word : idlen_word;
            last_q <= (beat_q == 2'd1) & LastEntry_SI;
         end
      end
   end

   assign out_if.OutValid_S = valid_q;
   assign out_if.OutData_D  = data_q;
   assign out_if.OutLast_S  = last_q;

endmodule

// File: rtl/axi_log_drain.sv
// Drains the AXI BRAM logger: fetch 3 words per entry, stream them out, then clear the logger.
module axi_log_drain
   import axi_log_pkg::*;
#(
   parameter int NUM_LOG_ENTRIES = 16384,
   parameter int BRAM_ADDR_BITW  = 32,
   parameter int CLR_WAIT_EXTRA  = 4
) (
   input  logic                                     Clk_CI,
   input  logic                                     Rst_RI,
   input  logic                                     Start_SI,
   input  logic                                     AutoDrain_SI,
   input  logic                                     LogFull_SI,
   input  logic                                     StopOnEmpty_SI,
   output logic                                     BramEn_SO,
   output logic [BRAM_ADDR_BITW-1:0]                BramAddr_SO,
   input  logic [LOG_WORD_BITW-1:0]                 BramRd_DI,
   output logic                                     Clear_SO,
   output logic                                     Busy_SO,
   output logic                                     Done_SO,
   output logic [$clog2(num_slots(NUM_LOG_ENTRIES)):0] EntryCnt_DO,
   axi_log_drain_if.master                          out_if
);

   localparam int NUM_SLOTS = num_slots(NUM_LOG_ENTRIES);
   localparam int ENTRY_W   = $clog2(NUM_SLOTS);
   localparam int CNT_W     = ENTRY_W + 1;
   localparam int WADDR_W   = $clog2(LOG_WORDS_PER_ENTRY * NUM_SLOTS);
   localparam int WAIT_W    = $clog2(NUM_SLOTS + CLR_WAIT_EXTRA);

   // Done rises NUM_SLOTS+CLR_WAIT_EXTRA cycles after the Clear pulse.
   localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(NUM_SLOTS + CLR_WAIT_EXTRA - 2);
   localparam logic [ENTRY_W-1:0] LAST_ENTRY = ENTRY_W'(NUM_SLOTS - 1);

   drain_state_e        state_q;
   logic                bram_en_q;
   logic [WADDR_W-1:0]  word_addr_q;
   logic [ENTRY_W-1:0]  entry_q;
   logic [CNT_W-1:0]    entry_cnt_q;
   logic [1:0]          phase_q;
   logic [WAIT_W-1:0]   wait_q;
   logic                clear_q;
   logic                done_q;

   logic cap_en, emit_start, all_zero, emit_done, drop_entry;
   logic [1:0] cap_idx;

   // Read data trails each enable by one cycle, so phases 1..3 capture words 0..2.
   assign cap_en     = (state_q == FETCH) && (phase_q != 2'd0);
   assign cap_idx    = phase_q - 2'd1;
   assign drop_entry = StopOnEmpty_SI & all_zero;
   assign emit_start = (state_q == CHECK) && !drop_entry;

   axi_log_entry_buf u_entry_buf (
      .Clk_CI       (Clk_CI),
      .Rst_RI       (Rst_RI),
      .CapEn_SI     (cap_en),
      .CapIdx_DI    (cap_idx),
      .CapData_DI   (BramRd_DI),
      .EmitStart_SI (emit_start),
      .LastEntry_SI (entry_q == LAST_ENTRY),
      .AllZero_SO   (all_zero),
      .EmitDone_SO  (emit_done),
      .out_if       (out_if)
   );

   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         state_q     <= IDLE;
         bram_en_q   <= 1'b0;
         word_addr_q <= '0;
         entry_q     <= '0;
         entry_cnt_q <= '0;
         phase_q     <= 2'd0;
         wait_q      <= '0;
         clear_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         clear_q <= 1'b0;
         done_q  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (Start_SI || (AutoDrain_SI && LogFull_SI)) begin
                  state_q     <= FETCH;
                  entry_q     <= '0;
                  entry_cnt_q <= '0;
                  word_addr_q <= '0;
                  bram_en_q   <= 1'b1;
                  phase_q     <= 2'd0;
               end
            end
            FETCH: begin
               // Address walks 3e, 3e+1, 3e+2 and rests on 3(e+1) for the next entry.
               phase_q <= phase_q + 2'd1;
               if (phase_q != 2'd3) word_addr_q <= word_addr_q + WADDR_W'(1);
               if (phase_q == 2'd2) bram_en_q <= 1'b0;
               if (phase_q == 2'd3) begin
                  phase_q <= 2'd0;
                  state_q <= CHECK;
               end
            end
            CHECK: begin
               if (drop_entry) begin
                  state_q <= CLEAR;
                  clear_q <= 1'b1;
               end else begin
                  state_q <= EMIT;
               end
            end
            EMIT: begin
               if (emit_done) begin
                  entry_cnt_q <= entry_cnt_q + CNT_W'(1);
                  if (entry_q == LAST_ENTRY) begin
                     state_q <= CLEAR;
                     clear_q <= 1'b1;
                  end else begin
                     entry_q   <= entry_q + ENTRY_W'(1);
                     state_q   <= FETCH;
                     bram_en_q <= 1'b1;
                     phase_q   <= 2'd0;
                  end
               end
            end
            CLEAR: begin
               state_q <= CLRWAIT;
               wait_q  <= '0;
            end
            CLRWAIT: begin
               if (wait_q == WAIT_LAST) begin
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  wait_q <= wait_q + WAIT_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign BramEn_SO   = bram_en_q;
   assign BramAddr_SO = BRAM_ADDR_BITW'({word_addr_q, 2'b00});
   assign Clear_SO    = clear_q;
   assign Done_SO     = done_q;
   assign Busy_SO     = (state_q != IDLE);
   assign EntryCnt_DO = entry_cnt_q;

endmodule

// File: tb/tb_axi_log_drain.sv
// Randomized bench for axi_log_drain against a queue-based model of the drained beat stream.
module tb_axi_log_drain;

   localparam int N  = 1024;
   localparam int NW = 3 * N;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        auto_drain = 1'b0;
   logic        log_full = 1'b0;
   logic        stop_on_empty = 1'b0;
   logic        bram_en;
   logic [31:0] bram_addr;
   logic [31:0] bram_rd = '0;
   logic        clear, busy, done;
   logic [10:0] entry_cnt;

   always #5 clk = ~clk;

   axi_log_drain_if out_if ();

   axi_log_drain #(.NUM_LOG_ENTRIES(N), .BRAM_ADDR_BITW(32), .CLR_WAIT_EXTRA(4)) dut (
      .Clk_CI         (clk),
      .Rst_RI         (rst),
      .Start_SI       (start),
      .AutoDrain_SI   (auto_drain),
      .LogFull_SI     (log_full),
      .StopOnEmpty_SI (stop_on_empty),
      .BramEn_SO      (bram_en),
      .BramAddr_SO    (bram_addr),
      .BramRd_DI      (bram_rd),
      .Clear_SO       (clear),
      .Busy_SO        (busy),
      .Done_SO        (done),
      .EntryCnt_DO    (entry_cnt),
      .out_if         (out_if)
   );

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } beat_t;

   logic [31:0] mem [NW];
   beat_t       exp_q [$];
   logic [31:0] got_q [$];
   logic [31:0] ref_q [$];
   int checks = 0, errors = 0;
   int exp_entries, exp_last;
   int cyc = 0, hs_cnt, last_cnt, clear_cnt, done_cnt, clear_cyc, done_cyc;
   int exp_rd_addr = 0;
   bit want_first = 1'b0;
   logic [31:0] first_addr = '1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // BRAM with one cycle of read latency.
   initial forever begin
      @(posedge clk);
      if (bram_en) bram_rd <= mem[bram_addr[13:2]];
   end

   // Random entries; entry 2 has only its top word set; zero_entry (if >= 0) is all-zero.
   task automatic fill_mem(input int zero_entry);
      for (int i = 0; i < NW; i++) mem[i] = $urandom;
      for (int e = 0; e < N; e++)
         if (mem[3*e] == 0 && mem[3*e+1] == 0 && mem[3*e+2] == 0) mem[3*e] = 32'h1;
      mem[6] = '0;
      mem[7] = '0;
      mem[8] = $urandom | 32'h100;
      if (zero_entry >= 0) begin
         mem[3*zero_entry] = '0;
         mem[3*zero_entry+1] = '0;
         mem[3*zero_entry+2] = '0;
      end
   endtask

   task automatic build_expected(input bit stop);
      beat_t b;
      exp_q.delete();
      exp_entries = 0;
      for (int e = 0; e < N; e++) begin
         if (stop && mem[3*e] == 0 && mem[3*e+1] == 0 && mem[3*e+2] == 0) break;
         for (int k = 0; k < 3; k++) begin
            b.data = mem[3*e+k];
            b.last = (e == N-1 && k == 2);
            exp_q.push_back(b);
         end
         exp_entries++;
      end
      exp_last = (exp_entries == N) ? 1 : 0;
   endtask

   task automatic reset_counters();
      hs_cnt = 0; last_cnt = 0; clear_cnt = 0; done_cnt = 0;
      clear_cyc = 0; done_cyc = 0; exp_rd_addr = 0;
      got_q.delete();
   endtask

   initial forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
         if (bram_en) begin
            check("bram_addr", bram_addr, exp_rd_addr);
            exp_rd_addr += 4;
            if (want_first) begin
               first_addr = bram_addr;
               want_first = 1'b0;
            end
         end
         if (out_if.OutValid_S) begin
            if (exp_q.size() == 0) begin
               check("extra_beat", 1, 0);
            end else begin
               check("beat_data", out_if.OutData_D, exp_q[0].data);
               if (out_if.OutReady_S) begin
                  check("beat_last", out_if.OutLast_S, exp_q[0].last);
                  got_q.push_back(out_if.OutData_D);
                  void'(exp_q.pop_front());
                  hs_cnt++;
                  if (out_if.OutLast_S) last_cnt++;
               end else begin
                  check("stall_bram_en", bram_en, 0);
               end
            end
         end
         if (clear) begin clear_cnt++; clear_cyc = cyc; end
         if (done) begin done_cnt++; done_cyc = cyc; end
      end
   end

   task automatic run_drain(input int pct, input bit stop, input bit use_auto, input int budget);
      int n;
      build_expected(stop);
      reset_counters();
      stop_on_empty = stop;
      out_if.OutReady_S = ($urandom_range(0, 99) < pct);
      if (use_auto) begin
         auto_drain = 1'b1;
         log_full = 1'b1;
      end else begin
         start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      log_full = 1'b0;
      auto_drain = 1'b0;
      check("busy_on_trigger", busy, 1);
      n = 0;
      while (done_cnt == 0 && n < budget) begin
         out_if.OutReady_S = ($urandom_range(0, 99) < pct);
         start = (n == 40);
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      if (done_cnt == 0) check("done_timeout", 0, 1);
      check("beats_left", exp_q.size(), 0);
      check("clear_pulses", clear_cnt, 1);
      check("done_delay", done_cyc - clear_cyc, 1028);
      check("entry_cnt", entry_cnt, exp_entries);
      check("last_beats", last_cnt, exp_last);
      repeat (5) @(posedge clk);
      #1;
      check("idle_after_done", busy, 0);
      check("done_count", done_cnt, 1);
   endtask

   initial begin
      int n;
      out_if.OutReady_S = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", out_if.OutValid_S, 0);
      check("rst_bram_en", bram_en, 0);
      check("rst_busy", busy, 0);
      check("rst_entry_cnt", entry_cnt, 0);
      rst = 1'b0;

      fill_mem(-1);
      run_drain(100, 1'b0, 1'b0, 20000);

      fill_mem(5);
      run_drain(50, 1'b1, 1'b0, 5000);

      fill_mem(40);
      run_drain(100, 1'b1, 1'b0, 5000);
      ref_q = got_q;
      run_drain(30, 1'b1, 1'b0, 8000);
      check("bp_seq_len", got_q.size(), ref_q.size());
      for (int i = 0; i < ref_q.size() && i < got_q.size(); i++)
         check("bp_seq", got_q[i], ref_q[i]);

      fill_mem(3);
      run_drain(50, 1'b1, 1'b1, 5000);
      auto_drain = 1'b0;
      log_full = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("no_auto_busy", busy, 0);
      log_full = 1'b0;

      // Stall on entry 7 beat 1, then reset mid-EMIT.
      fill_mem(10);
      build_expected(1'b1);
      reset_counters();
      stop_on_empty = 1'b1;
      out_if.OutReady_S = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (hs_cnt < 22 && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      out_if.OutReady_S = 1'b0;
      check("rst_reach_beat", hs_cnt, 22);
      repeat (3) @(posedge clk);
      #1;
      check("rst_stalled_valid", out_if.OutValid_S, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_rst_valid", out_if.OutValid_S, 0);
      check("mid_rst_data", out_if.OutData_D, 0);
      check("mid_rst_last", out_if.OutLast_S, 0);
      check("mid_rst_bram_en", bram_en, 0);
      check("mid_rst_addr", bram_addr, 0);
      check("mid_rst_clear", clear, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_entry_cnt", entry_cnt, 0);
      want_first = 1'b1;
      run_drain(100, 1'b1, 1'b0, 5000);
      check("restart_addr", first_addr, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
